// File: rtl/cpu_ddr_bridge_arbiter.sv
// Two-master (CPU, video DMA) arbiter in front of a clock-bridge slave; a tag FIFO routes read data.
// Define ARB_FIXED_PRIORITY_EN to make m0 win every contention instead of round-robin.
module cpu_ddr_bridge_arbiter #(
   parameter int unsigned MAX_PENDING = 8,
   parameter int unsigned AW          = 24
) (
   input  logic          slave_clk,
   input  logic          slave_reset_n,
   input  logic [AW-1:0] m0_address,
   input  logic [3:0]    m0_byteenable,
   input  logic          m0_read,
   input  logic          m0_write,
   input  logic [31:0]   m0_writedata,
   output logic          m0_waitrequest,
   output logic [31:0]   m0_readdata,
   output logic          m0_readdatavalid,
   output logic          m0_endofpacket,
   input  logic [AW-1:0] m1_address,
   input  logic [3:0]    m1_byteenable,
   input  logic          m1_read,
   input  logic          m1_write,
   input  logic [31:0]   m1_writedata,
   output logic          m1_waitrequest,
   output logic [31:0]   m1_readdata,
   output logic          m1_readdatavalid,
   output logic          m1_endofpacket,
   output logic [AW-1:0] br_address,
   output logic [3:0]    br_byteenable,
   output logic          br_read,
   output logic          br_write,
   output logic [31:0]   br_writedata,
   input  logic          br_waitrequest,
   input  logic [31:0]   br_readdata,
   input  logic          br_readdatavalid,
   input  logic          br_endofpacket,
   output logic          arb_error
);
   localparam int unsigned CW = $clog2(MAX_PENDING + 1);
   localparam int unsigned PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [MAX_PENDING-1:0] tag_q;
   logic                   err_q;

   logic owned, owner, c_read, c_write, req0, req1, grant;
   logic pop, push, full, rd_go, wr_go, accept, head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_PENDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

`ifdef ARB_FIXED_PRIORITY_EN
   assign grant = ~req0;
`else
   logic last_q;

   // last_q holds the id granted most recently; the other requester wins a tie.
   assign grant = (req0 & req1) ? ~last_q : req1;

   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         last_q <= 1'b1;
      end else if (state_q == StIdle && (req0 | req1)) begin
         last_q <= grant;
      end
   end
`endif

   assign owned   = (state_q != StIdle);
   assign owner   = (state_q == StOwn1);
   assign c_read  = owner ? m1_read  : m0_read;
   assign c_write = owner ? m1_write : m0_write;

   assign pop    = br_readdatavalid & (cnt_q != '0);
   assign full   = (cnt_q == CW'(MAX_PENDING)) & ~pop;
   assign rd_go  = owned & c_read & ~full;
   assign wr_go  = owned & c_write;
   assign accept = (rd_go | wr_go) & ~br_waitrequest;
   assign push   = accept & rd_go;
   assign head   = tag_q[rd_ptr_q];

   // Data-path outputs are forced low while reset is asserted.
   assign br_address       = slave_reset_n ? (owner ? m1_address    : m0_address)    : '0;
   assign br_byteenable    = slave_reset_n ? (owner ? m1_byteenable : m0_byteenable) : '0;
   assign br_writedata     = slave_reset_n ? (owner ? m1_writedata  : m0_writedata)  : '0;
   assign br_read          = rd_go;
   assign br_write         = wr_go;
   assign m0_waitrequest   = ~(accept & ~owner);
   assign m1_waitrequest   = ~(accept & owner);
   assign m0_readdatavalid = pop & ~head;
   assign m1_readdatavalid = pop & head;
   assign m0_readdata      = slave_reset_n ? br_readdata : '0;
   assign m1_readdata      = slave_reset_n ? br_readdata : '0;
   assign m0_endofpacket   = slave_reset_n & br_endofpacket;
   assign m1_endofpacket   = slave_reset_n & br_endofpacket;
   assign arb_error        = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      unique case (state_q)
         StIdle: begin
            if (req0 | req1) state_d = grant ? StOwn1 : StOwn0;
         end
         StOwn0, StOwn1: begin
            if (accept || !(c_read || c_write)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         tag_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (push) begin
            tag_q[wr_ptr_q] <= owner;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (br_readdatavalid && cnt_q == '0) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_ddr_bridge_arbiter.sv
// Self-checking bench for cpu_ddr_bridge_arbiter: directed scenarios plus a randomized run
// checked every cycle against a queue-based reference model.
module tb_cpu_ddr_bridge_arbiter;
   localparam int unsigned MAX_PENDING = 8;
   localparam int unsigned AW          = 24;
   localparam int          IDLE_ID     = 2;
`ifdef ARB_FIXED_PRIORITY_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          slave_clk, slave_reset_n;
   logic [AW-1:0] m0_address, m1_address, br_address;
   logic [3:0]    m0_byteenable, m1_byteenable, br_byteenable;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [31:0]   m0_writedata, m1_writedata, br_writedata;
   logic          m0_waitrequest, m1_waitrequest;
   logic [31:0]   m0_readdata, m1_readdata, br_readdata;
   logic          m0_readdatavalid, m1_readdatavalid, m0_endofpacket, m1_endofpacket;
   logic          br_read, br_write, br_waitrequest, br_readdatavalid, br_endofpacket;
   logic          arb_error;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: current owner, last grant, queue of pending read owners, sticky error.
   int owner = IDLE_ID;
   bit last  = 1'b1;
   bit err   = 1'b0;
   bit pend[$];
   int obs[$];

   cpu_ddr_bridge_arbiter #(.MAX_PENDING(MAX_PENDING), .AW(AW)) dut (
      .slave_clk       (slave_clk),
      .slave_reset_n   (slave_reset_n),
      .m0_address      (m0_address),
      .m0_byteenable   (m0_byteenable),
      .m0_read         (m0_read),
      .m0_write        (m0_write),
      .m0_writedata    (m0_writedata),
      .m0_waitrequest  (m0_waitrequest),
      .m0_readdata     (m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m0_endofpacket  (m0_endofpacket),
      .m1_address      (m1_address),
      .m1_byteenable   (m1_byteenable),
      .m1_read         (m1_read),
      .m1_write        (m1_write),
      .m1_writedata    (m1_writedata),
      .m1_waitrequest  (m1_waitrequest),
      .m1_readdata     (m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .m1_endofpacket  (m1_endofpacket),
      .br_address      (br_address),
      .br_byteenable   (br_byteenable),
      .br_read         (br_read),
      .br_write        (br_write),
      .br_writedata    (br_writedata),
      .br_waitrequest  (br_waitrequest),
      .br_readdata     (br_readdata),
      .br_readdatavalid(br_readdatavalid),
      .br_endofpacket  (br_endofpacket),
      .arb_error       (arb_error)
   );

   initial begin
      slave_clk = 1'b0;
      forever #5 slave_clk = ~slave_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
      m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
      br_waitrequest = 0; br_readdata = '0; br_readdatavalid = 0; br_endofpacket = 0;
   endtask

   task automatic model_reset();
      owner = IDLE_ID;
      last  = 1'b1;
      err   = 1'b0;
      pend.delete();
      obs.delete();
   endtask

   task automatic do_reset();
      @(negedge slave_clk);
      slave_reset_n = 0;
      clear_inputs();
      repeat (2) @(negedge slave_clk);
      slave_reset_n = 1;
      model_reset();
   endtask

   // One clock cycle: called at a negedge with inputs already driven; compares DUT outputs with
   // the model, records observed grants, advances the model at the posedge, returns at negedge.
   task automatic cycle();
      bit         pop, full, rd, wr, acc, head, cr, cw, req0, req1;
      int         nxt;
      logic [6:0] exp_v, got_v;
      #1;
      head = (pend.size() > 0) ? pend[0] : 1'b0;
      pop  = br_readdatavalid && (pend.size() > 0);
      full = (pend.size() == MAX_PENDING) && !pop;
      cr   = (owner == 1) ? m1_read : m0_read;
      cw   = (owner == 1) ? m1_write : m0_write;
      rd   = (owner != IDLE_ID) && cr && !full;
      wr   = (owner != IDLE_ID) && cw;
      acc  = (rd || wr) && !br_waitrequest;
      exp_v = {rd, wr, !(acc && owner == 0), !(acc && owner == 1), pop && !head, pop && head, err};
      got_v = {br_read, br_write, m0_waitrequest, m1_waitrequest,
               m0_readdatavalid, m1_readdatavalid, arb_error};
      n_total++;
      if (got_v !== exp_v)
         $display("FAIL model_ctrl @%0t: got %b required %b", $time, got_v, exp_v);
      else n_pass++;
      n_total++;
      if ({br_address, br_byteenable, br_writedata} !==
          ((owner == 1) ? {m1_address, m1_byteenable, m1_writedata}
                        : {m0_address, m0_byteenable, m0_writedata}))
         $display("FAIL model_cmd @%0t: got %h/%h/%h", $time, br_address, br_byteenable,
                  br_writedata);
      else n_pass++;
      n_total++;
      if ({m0_readdata, m1_readdata, m0_endofpacket, m1_endofpacket} !==
          {br_readdata, br_readdata, br_endofpacket, br_endofpacket})
         $display("FAIL model_rdata @%0t: got %h/%h required %h", $time, m0_readdata,
                  m1_readdata, br_readdata);
      else n_pass++;
      if (!m0_waitrequest) obs.push_back(0);
      if (!m1_waitrequest) obs.push_back(1);
      req0 = m0_read || m0_write;
      req1 = m1_read || m1_write;
      @(posedge slave_clk);
      if (pop) void'(pend.pop_front());
      else if (br_readdatavalid) err = 1'b1;
      if (acc && rd) pend.push_back(owner[0]);
      if (owner == IDLE_ID) begin
         if (req0 && req1) nxt = FIXED ? 0 : (last ? 0 : 1);
         else if (req0)    nxt = 0;
         else if (req1)    nxt = 1;
         else              nxt = IDLE_ID;
         if (nxt != IDLE_ID) last = nxt[0];
         owner = nxt;
      end else if (acc || !(cr || cw)) begin
         owner = IDLE_ID;
      end
      @(negedge slave_clk);
   endtask

   task automatic drain();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; br_waitrequest = 0;
      for (int i = 0; i < 60 && pend.size() > 0; i++) begin
         br_readdatavalid = 1;
         br_readdata      = $urandom;
         cycle();
      end
      br_readdatavalid = 0;
      cycle();
   endtask

   task automatic test_reset();
      clear_inputs();
      slave_reset_n = 0;
      m0_address = 24'hABCDEF; m0_byteenable = 4'hF; m0_writedata = 32'hCAFE_F00D;
      m0_read = 1; br_readdata = 32'hDEAD_BEEF; br_endofpacket = 1; br_readdatavalid = 1;
      #3;
      n_total++;
      if ({br_address, br_byteenable, br_writedata, br_read, br_write} !== '0)
         $display("FAIL reset_br: got %h %h %h %b%b required all 0", br_address, br_byteenable,
                  br_writedata, br_read, br_write);
      else n_pass++;
      n_total++;
      if ({m0_waitrequest, m1_waitrequest} !== 2'b11)
         $display("FAIL reset_wait: got %b required 11", {m0_waitrequest, m1_waitrequest});
      else n_pass++;
      n_total++;
      if ({m0_readdata, m1_readdata, m0_readdatavalid, m1_readdatavalid,
           m0_endofpacket, m1_endofpacket, arb_error} !== '0)
         $display("FAIL reset_resp: got %h %h %b%b%b%b%b required all 0", m0_readdata,
                  m1_readdata, m0_readdatavalid, m1_readdatavalid, m0_endofpacket,
                  m1_endofpacket, arb_error);
      else n_pass++;
      clear_inputs();
      @(negedge slave_clk);
      slave_reset_n = 1;
      model_reset();
      m0_address = 24'h123456;
      repeat (2) cycle();
   endtask

   task automatic test_round_robin();
      do_reset();
      m0_read = 1; m1_read = 1;
      m0_address = 24'h000010; m1_address = 24'h000020;
      for (int i = 0; i < 20 && obs.size() < 4; i++) cycle();
      m0_read = 0; m1_read = 0;
      n_total++;
      if (obs.size() != 4) $display("FAIL rr_count: got %0d grants required 4", obs.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         int want;
         want = FIXED ? 0 : (i % 2);
         n_total++;
         if (i >= obs.size() || obs[i] != want)
            $display("FAIL rr_grant%0d: got %0d required %0d", i,
                     (i < obs.size()) ? obs[i] : -1, want);
         else n_pass++;
      end
      drain();
   endtask

   task automatic test_full_stall();
      do_reset();
      m1_read = 1; m1_address = 24'h00ABC0;
      for (int i = 0; i < 40 && obs.size() < 8; i++) cycle();
      repeat (3) cycle();
      #1;
      n_total++;
      if (obs.size() != 8 || br_read !== 1'b0 || m1_waitrequest !== 1'b1)
         $display("FAIL full_stall: grants %0d br_read %b m1_wait %b required 8 0 1",
                  obs.size(), br_read, m1_waitrequest);
      else n_pass++;
      br_readdatavalid = 1; br_readdata = 32'h0000_1111;
      cycle();
      br_readdatavalid = 0; m1_read = 0;
      cycle();
      n_total++;
      if (obs.size() != 9) $display("FAIL full_resume: got %0d grants required 9", obs.size());
      else n_pass++;
      drain();
   endtask

   task automatic test_read_return();
      do_reset();
      m0_read = 1; m0_address = 24'h000040;
      for (int i = 0; i < 10 && obs.size() < 1; i++) cycle();
      m0_read = 0;
      m1_read = 1; m1_address = 24'h000080;
      for (int i = 0; i < 10 && obs.size() < 2; i++) cycle();
      m1_read = 0;
      n_total++;
      if (obs.size() != 2 || obs[0] != 0 || obs[1] != 1)
         $display("FAIL rr_order: got %0d grants required m0 then m1", obs.size());
      else n_pass++;
      br_readdatavalid = 1; br_readdata = 32'hA5A5_0000;
      #1;
      n_total++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10 || m0_readdata !== 32'hA5A5_0000)
         $display("FAIL ret_first: got rdv %b data %h required 10 a5a50000",
                  {m0_readdatavalid, m1_readdatavalid}, m0_readdata);
      else n_pass++;
      cycle();
      br_readdata = 32'h5A5A_0001;
      #1;
      n_total++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== 32'h5A5A_0001)
         $display("FAIL ret_second: got rdv %b data %h required 01 5a5a0001",
                  {m0_readdatavalid, m1_readdatavalid}, m1_readdata);
      else n_pass++;
      cycle();
      br_readdatavalid = 0;
      cycle();
   endtask

   task automatic test_write_wait();
      do_reset();
      m0_write = 1; m0_address = 24'h000100; m0_writedata = 32'h1234_5678; m0_byteenable = 4'hF;
      m1_read = 1; m1_address = 24'h000200; br_waitrequest = 1;
      cycle();
      for (int i = 0; i < 5; i++) begin
         #1;
         n_total++;
         if ({br_write, br_read, br_address, br_writedata, br_byteenable, m0_waitrequest,
              m1_waitrequest} !== {1'b1, 1'b0, 24'h000100, 32'h1234_5678, 4'hF, 1'b1, 1'b1})
            $display("FAIL wr_hold%0d: got w%b r%b %h %h wait %b%b", i, br_write, br_read,
                     br_address, br_writedata, m0_waitrequest, m1_waitrequest);
         else n_pass++;
         cycle();
      end
      br_waitrequest = 0;
      #1;
      n_total++;
      if (m0_waitrequest !== 1'b0 || br_write !== 1'b1)
         $display("FAIL wr_accept: got m0_wait %b br_write %b required 0 1",
                  m0_waitrequest, br_write);
      else n_pass++;
      cycle();
      m0_write = 0;
      n_total++;
      if (obs.size() != 1 || obs[0] != 0)
         $display("FAIL wr_excl: got %0d grants required only m0", obs.size());
      else n_pass++;
      for (int i = 0; i < 10 && obs.size() < 2; i++) cycle();
      m1_read = 0;
      drain();
   endtask

   task automatic test_error();
      do_reset();
      br_readdatavalid = 1; br_readdata = 32'h7777_7777;
      #1;
      n_total++;
      if ({m0_readdatavalid, m1_readdatavalid, arb_error} !== 3'b000)
         $display("FAIL err_norv: got %b required 000",
                  {m0_readdatavalid, m1_readdatavalid, arb_error});
      else n_pass++;
      cycle();
      br_readdatavalid = 0;
      #1;
      n_total++;
      if (arb_error !== 1'b1) $display("FAIL err_set: got %b required 1", arb_error);
      else n_pass++;
      repeat (5) cycle();
      n_total++;
      if (arb_error !== 1'b1) $display("FAIL err_sticky: got %b required 1", arb_error);
      else n_pass++;
      slave_reset_n = 0;
      #1;
      n_total++;
      if (arb_error !== 1'b0) $display("FAIL err_clear: got %b required 0", arb_error);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_reset_mid();
      do_reset();
      m1_read = 1; m1_address = 24'h000300;
      for (int i = 0; i < 20 && obs.size() < 3; i++) cycle();
      br_waitrequest = 1;
      cycle();
      #1;
      n_total++;
      if (br_read !== 1'b1 || pend.size() != 3)
         $display("FAIL mid_setup: got br_read %b pending %0d required 1 3", br_read,
                  pend.size());
      else n_pass++;
      #1;
      slave_reset_n = 0;
      #1;
      n_total++;
      if ({br_read, br_write, m0_waitrequest, m1_waitrequest} !== 4'b0011)
         $display("FAIL mid_async: got %b required 0011",
                  {br_read, br_write, m0_waitrequest, m1_waitrequest});
      else n_pass++;
      @(posedge slave_clk);
      #1;
      n_total++;
      if ({br_read, br_write, m1_waitrequest} !== 3'b001)
         $display("FAIL mid_edge: got %b required 001", {br_read, br_write, m1_waitrequest});
      else n_pass++;
      m1_read = 0; br_waitrequest = 0;
      @(negedge slave_clk);
      slave_reset_n = 1;
      model_reset();
      br_readdatavalid = 1;
      cycle();
      br_readdatavalid = 0;
      #1;
      n_total++;
      if (arb_error !== 1'b1) $display("FAIL mid_discard: got %b required 1", arb_error);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         m0_read  = ($urandom_range(0, 2) == 0);
         m0_write = !m0_read && ($urandom_range(0, 4) == 0);
         m1_read  = ($urandom_range(0, 2) == 0);
         m1_write = !m1_read && ($urandom_range(0, 4) == 0);
         m0_address = AW'($urandom); m1_address = AW'($urandom);
         m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
         m0_writedata = $urandom; m1_writedata = $urandom;
         br_waitrequest   = ($urandom_range(0, 3) == 0);
         br_readdatavalid = (pend.size() > 0) && ($urandom_range(0, 5) == 0);
         br_readdata      = $urandom;
         br_endofpacket   = 1'($urandom_range(0, 1));
         cycle();
      end
      drain();
      n_total++;
      if (arb_error !== 1'b0) $display("FAIL rand_noerr: got %b required 0", arb_error);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_full_stall();
      test_read_return();
      test_write_wait();
      test_error();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cpu_ddr_bridge_arbiter.md
CPU_DDR_BRIDGE_ARBITER -- requirements
Module: cpu_ddr_bridge_arbiter

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 8, maximum accepted-but-unreturned reads (range 1..16).
REQ-002 SHALL have parameter AW, default 24, word address width.
REQ-003 SHALL have port slave_clk input 1: clock for the whole block.
REQ-004 SHALL have port slave_reset_n input 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports mN_address input AW, mN_byteenable input 4, mN_read input 1, mN_write input 1, mN_writedata input 32 (N=0,1): requester N command (m0=CPU, m1=video DMA).
REQ-006 SHALL have ports mN_waitrequest output 1, mN_readdata output 32, mN_readdatavalid output 1, mN_endofpacket output 1 (N=0,1): requester N response.
REQ-007 SHALL have ports br_address output AW, br_byteenable output 4, br_read output 1, br_write output 1, br_writedata output 32: command to the clock-bridge slave port.
REQ-008 SHALL have ports br_waitrequest input 1, br_readdata input 32, br_readdatavalid input 1, br_endofpacket input 1: clock-bridge slave response.
REQ-009 SHALL have port arb_error output 1: sticky flag, readdatavalid received with no read pending.

Function
REQ-010 SHALL implement FSM states IDLE, OWN0, OWN1; reset state IDLE.
REQ-011 In IDLE with a requester asserting read or write, SHALL select an owner per REQ-021 and transition to OWNx next cycle; no request, stay IDLE.
REQ-012 In OWNx, br_* command outputs SHALL equal mx_* inputs; in IDLE, br_read=br_write=0, other br_* outputs driven from m0.
REQ-013 Transfer accepted when (br_read|br_write)=1 and br_waitrequest=0 in OWNx; on acceptance SHALL return to IDLE (one dead cycle per transfer, throughput 1 per 2 cycles).
REQ-014 In OWNx with neither mx_read nor mx_write asserted, SHALL return to IDLE next cycle.
REQ-015 mx_waitrequest SHALL be 0 only in the acceptance cycle of REQ-013 with owner x; 1 otherwise, including IDLE and reset.
REQ-016 SHALL maintain pending-read count, width clog2(MAX_PENDING+1), and a tag FIFO of MAX_PENDING 1-bit owner IDs.
REQ-017 On an accepted read, SHALL push the owner ID and increment count; on br_readdatavalid, SHALL pop and decrement; both in one cycle: push and pop performed, count unchanged.
REQ-018 When count==MAX_PENDING and no pop occurs that cycle, SHALL hold br_read=0 and keep mx_waitrequest=1 for a read in OWNx; writes SHALL not be blocked.
REQ-019 mN_readdatavalid SHALL equal br_readdatavalid AND (FIFO head ID==N); mN_readdata/mN_endofpacket SHALL be br_readdata/br_endofpacket to both requesters (zero-latency, combinational).
REQ-020 br_readdatavalid with count==0 SHALL set arb_error, assert no mN_readdatavalid, and leave count at 0; arb_error cleared only by reset.
REQ-021 Arbitration SHALL be round-robin: last-granted register (reset value 1, so m0 wins first tie); requester other than last-granted wins when both request; single requester always wins.
REQ-022 Tag FIFO pointers SHALL wrap modulo MAX_PENDING.

Reset
REQ-023 slave_reset_n low SHALL asynchronously force IDLE, count=0, FIFO pointers=0, last-granted=1, arb_error=0.
REQ-024 During reset all outputs SHALL be 0 except mN_waitrequest=1; reads outstanding at reset SHALL be discarded, their later readdatavalid flagged per REQ-020.

Configuration
REQ-025 Macro ARB_FIXED_PRIORITY_EN: defined, m0 SHALL win every contention (last-granted register unused); undefined, round-robin per REQ-021.

Verification
REQ-026 Both requesters assert read continuously, br_waitrequest=0: grants alternate m0,m1,m0,m1 (round-robin build); m0 every grant (ARB_FIXED_PRIORITY_EN build).
REQ-027 m1 issues 8 reads, bridge withholds readdatavalid: 9th read stalls, br_read=0, m1_waitrequest=1; one readdatavalid then 9th read accepted within 2 cycles.
REQ-028 m0 read then m1 read accepted, two readdatavalid with data 0xA5A5_0000, 0x5A5A_0001: m0_readdatavalid on first, m1_readdatavalid on second, never both.
REQ-029 br_waitrequest held 5 cycles during m0 write 0x1234_5678 @0x000100: br_* stable 5 cycles, m0_waitrequest=1, accepted on 6th, m1 not granted meanwhile.
REQ-030 br_readdatavalid with count=0: arb_error=1 next cycle, stays 1 until slave_reset_n low.
REQ-031 slave_reset_n low mid-OWN1 with 3 reads pending: next edge IDLE, count=0, all br_read/br_write=0.
